// File: rtl/regfile_banked_pkg.sv
// Shared constants for the banked ARM register file: mode encodings and the
// physical register layout. The REGFILE_FIQ_BANK_EN option is resolved in regfile_bank_map.
package regfile_banked_pkg;

    typedef logic [4:0] phys_idx_t;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    // r0-r14 user bank sits at 0..14, so user r13/r14 live at 13/14
    localparam phys_idx_t PHYS_USR_BASE = 5'd0;
    localparam phys_idx_t PHYS_USR_SP   = PHYS_USR_BASE + 5'd13;
    localparam phys_idx_t PHYS_FIQ_HI   = PHYS_USR_BASE + 5'd15;
    localparam phys_idx_t PHYS_FIQ_SP   = PHYS_FIQ_HI + 5'd5;
    localparam phys_idx_t PHYS_IRQ_SP   = PHYS_FIQ_SP + 5'd2;
    localparam phys_idx_t PHYS_SVC_SP   = PHYS_IRQ_SP + 5'd2;
    localparam phys_idx_t PHYS_ABT_SP   = PHYS_SVC_SP + 5'd2;
    localparam phys_idx_t PHYS_UND_SP   = PHYS_ABT_SP + 5'd2;
    localparam int        PHYS_COUNT    = int'(PHYS_UND_SP) + 2;

    function automatic phys_idx_t sp_base(input logic [4:0] mode);
        case (mode)
            MODE_FIQ:           sp_base = PHYS_FIQ_SP;
            MODE_IRQ:           sp_base = PHYS_IRQ_SP;
            MODE_SVC:           sp_base = PHYS_SVC_SP;
            MODE_ABT:           sp_base = PHYS_ABT_SP;
            MODE_UND:           sp_base = PHYS_UND_SP;
            MODE_USR, MODE_SYS: sp_base = PHYS_USR_SP;
            default:            sp_base = PHYS_USR_SP;
        endcase
    endfunction

endpackage

// File: rtl/regfile_bank_map.sv
// (architectural register, mode) -> physical index. With REGFILE_FIQ_BANK_EN
// defined, FIQ mode also banks r8-r12; otherwise the FIQ-high indices never occur.
module regfile_bank_map
    import regfile_banked_pkg::*;
(
    input  logic [3:0] arch_reg,
    input  logic [4:0] mode,
    output phys_idx_t  phys_idx
);

    logic [3:0] hi_off;

    always_comb begin
        hi_off   = arch_reg - 4'd8;
        phys_idx = PHYS_USR_BASE + phys_idx_t'({1'b0, arch_reg});
        if (arch_reg == 4'd13 || arch_reg == 4'd14) begin
            phys_idx = sp_base(mode) + phys_idx_t'({4'd0, arch_reg == 4'd14});
        end
`ifdef REGFILE_FIQ_BANK_EN
        if (mode == MODE_FIQ && arch_reg >= 4'd8 && arch_reg <= 4'd12) begin
            phys_idx = PHYS_FIQ_HI + phys_idx_t'({1'b0, hi_off});
        end
`endif
    end

endmodule

// File: rtl/regfile_banked.sv
// Banked ARM register file: one write port, three combinational read ports with
// write forwarding on physical index. FIQ r8-r12 banking via REGFILE_FIQ_BANK_EN.
module regfile_banked
    import regfile_banked_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        regfile_write,
    input  logic [3:0]  regfile_write_reg,
    input  logic [31:0] regfile_write_data,
    input  logic [4:0]  write_mode,
    input  logic [4:0]  read_mode,
    input  logic        read_user,
    input  logic [31:0] read_pc,
    input  logic [3:0]  read_0,
    input  logic [3:0]  read_1,
    input  logic [3:0]  read_2,
    output logic [31:0] rdata_0,
    output logic [31:0] rdata_1,
    output logic [31:0] rdata_2
);

    // Without the FIQ bank the FIQ-high entries are never written and reduce to constants.
    logic [31:0] regs [PHYS_COUNT];
    logic [3:0]  rsel  [3];
    phys_idx_t   ridx  [3];
    logic [31:0] rdata [3];
    phys_idx_t   widx;
    logic [4:0]  rmode;
    logic        wr_en;

    assign rmode   = read_user ? MODE_USR : read_mode;
    assign wr_en   = regfile_write && (regfile_write_reg != 4'd15) && !rst;
    assign rsel[0] = read_0;
    assign rsel[1] = read_1;
    assign rsel[2] = read_2;
    assign rdata_0 = rdata[0];
    assign rdata_1 = rdata[1];
    assign rdata_2 = rdata[2];

    regfile_bank_map u_map_wr (
        .arch_reg (regfile_write_reg),
        .mode     (write_mode),
        .phys_idx (widx)
    );

    for (genvar g = 0; g < 3; g++) begin : g_rd
        regfile_bank_map u_map_rd (
            .arch_reg (rsel[g]),
            .mode     (rmode),
            .phys_idx (ridx[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHYS_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[widx] <= regfile_write_data;
        end
    end

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            if (rsel[n] == 4'd15) begin
                rdata[n] = read_pc;
            end else if (rst) begin
                rdata[n] = '0;
            end else if (wr_en && widx == ridx[n]) begin
                rdata[n] = regfile_write_data;
            end else begin
                rdata[n] = regs[ridx[n]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_banked.sv
// Scoreboard bench for regfile_banked; expectations follow REGFILE_FIQ_BANK_EN.
module tb_regfile_banked;

    localparam logic [4:0] M_USR = 5'b10000;
    localparam logic [4:0] M_FIQ = 5'b10001;
    localparam logic [4:0] M_IRQ = 5'b10010;
    localparam logic [4:0] M_SVC = 5'b10011;
    localparam logic [4:0] M_ABT = 5'b10111;
    localparam logic [4:0] M_UND = 5'b11011;
    localparam logic [4:0] M_SYS = 5'b11111;

`ifdef REGFILE_FIQ_BANK_EN
    localparam bit FIQ_EN = 1'b1;
`else
    localparam bit FIQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        regfile_write = 1'b0;
    logic [3:0]  regfile_write_reg = '0;
    logic [31:0] regfile_write_data = '0;
    logic [4:0]  write_mode = M_USR;
    logic [4:0]  read_mode = M_USR;
    logic        read_user = 1'b0;
    logic [31:0] read_pc = '0;
    logic [3:0]  read_0 = '0, read_1 = '0, read_2 = '0;
    logic [31:0] rdata_0, rdata_1, rdata_2;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_banked dut (
        .clk                (clk),
        .rst                (rst),
        .regfile_write      (regfile_write),
        .regfile_write_reg  (regfile_write_reg),
        .regfile_write_data (regfile_write_data),
        .write_mode         (write_mode),
        .read_mode          (read_mode),
        .read_user          (read_user),
        .read_pc            (read_pc),
        .read_0             (read_0),
        .read_1             (read_1),
        .read_2             (read_2),
        .rdata_0            (rdata_0),
        .rdata_1            (rdata_1),
        .rdata_2            (rdata_2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int port, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.port = port; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] got;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = (e.port == 0) ? rdata_0 : (e.port == 1) ? rdata_1 : rdata_2;
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] mode, input logic usr,
                      input logic [3:0] r, input logic [31:0] exp);
        read_mode = mode; read_user = usr;
        read_0 = r; read_1 = r; read_2 = r;
        push({tag, "_p0"}, 0, exp);
        push({tag, "_p1"}, 1, exp);
        push({tag, "_p2"}, 2, exp);
        drain();
        read_user = 1'b0;
    endtask

    task automatic wr(input logic [3:0] r, input logic [4:0] mode, input logic [31:0] d);
        @(negedge clk);
        regfile_write = 1'b1; regfile_write_reg = r;
        write_mode = mode; regfile_write_data = d;
        @(negedge clk);
        regfile_write = 1'b0;
    endtask

    function automatic logic [31:0] usr_val(input int r);
        case (r)
            3:       usr_val = 32'hDEADBEEF;
            9:       usr_val = FIQ_EN ? 32'h0 : 32'h99;
            13:      usr_val = 32'h5555;
            default: usr_val = 32'h0;
        endcase
    endfunction

    logic [4:0] modes [7];

    initial begin
        modes = '{M_USR, M_FIQ, M_IRQ, M_SVC, M_ABT, M_UND, M_SYS};
        #1 rst = 1'b1;
        read_pc = 32'h1008;
        read_0 = 4'd15; read_1 = 4'd15; read_2 = 4'd15;
        push("rst_pc_p0", 0, 32'h1008);
        push("rst_pc_p2", 2, 32'h1008);
        drain();
        @(negedge clk);
        rst = 1'b0;

        // Reset state across all modes
        for (int m = 0; m < 7; m++) begin
            for (int r = 0; r < 15; r++) begin
                @(negedge clk);
                read_mode = modes[m];
                read_0 = 4'(r); read_1 = 4'(r); read_2 = 4'd15;
                push($sformatf("rst_m%0d_r%0d", m, r), 0, 32'h0);
                push($sformatf("rst_m%0d_r%0d_b", m, r), 1, 32'h0);
                push($sformatf("rst_m%0d_pc", m), 2, 32'h1008);
                drain();
            end
        end

        // Banked r13
        wr(4'd13, M_SVC, 32'hAAAA0000);
        wr(4'd13, M_USR, 32'h5555);
        rd("r13_svc", M_SVC, 1'b0, 4'd13, 32'hAAAA0000);
        rd("r13_usr", M_USR, 1'b0, 4'd13, 32'h5555);
        rd("r13_sys", M_SYS, 1'b0, 4'd13, 32'h5555);
        rd("r13_irq", M_IRQ, 1'b0, 4'd13, 32'h0);
        rd("r13_bad", 5'b00000, 1'b0, 4'd13, 32'h5555);
        rd("r13_svc_user", M_SVC, 1'b1, 4'd13, 32'h5555);

        // FIQ r8-r12 banking
        wr(4'd9, M_FIQ, 32'h99);
        rd("r9_fiq", M_FIQ, 1'b0, 4'd9, 32'h99);
        rd("r9_usr", M_USR, 1'b0, 4'd9, FIQ_EN ? 32'h0 : 32'h99);
        rd("r9_fiq_user", M_FIQ, 1'b1, 4'd9, FIQ_EN ? 32'h0 : 32'h99);

        // Same-cycle forwarding
        @(negedge clk);
        regfile_write = 1'b1; regfile_write_reg = 4'd3;
        write_mode = M_USR; regfile_write_data = 32'hDEADBEEF;
        read_mode = M_USR; read_0 = 4'd3; read_1 = 4'd4; read_2 = 4'd3;
        push("fwd_r3_p0", 0, 32'hDEADBEEF);
        push("fwd_r4_p1", 1, 32'h0);
        push("fwd_r3_p2", 2, 32'hDEADBEEF);
        drain();
        @(negedge clk);
        regfile_write_reg = 4'd14; write_mode = M_IRQ; regfile_write_data = 32'h1414;
        read_mode = M_USR; read_0 = 4'd14; read_1 = 4'd3; read_2 = 4'd14;
        push("nofwd_r14_p0", 0, 32'h0);
        push("r3_stored", 1, 32'hDEADBEEF);
        push("nofwd_r14_p2", 2, 32'h0);
        drain();
        @(negedge clk);
        regfile_write = 1'b0;
        rd("r14_irq", M_IRQ, 1'b0, 4'd14, 32'h1414);
        rd("r14_usr", M_USR, 1'b0, 4'd14, 32'h0);

        // Write to r15 is dropped
        @(negedge clk);
        regfile_write = 1'b1; regfile_write_reg = 4'd15;
        write_mode = M_USR; regfile_write_data = 32'h1234;
        read_pc = 32'h2008;
        rd("r15_wr_pc", M_USR, 1'b0, 4'd15, 32'h2008);
        @(negedge clk);
        regfile_write = 1'b0;
        for (int r = 0; r < 15; r++) begin
            rd($sformatf("post_r15_r%0d", r), M_USR, 1'b0, 4'(r), usr_val(r));
        end

        // Async reset mid-cycle
        wr(4'd1, M_USR, 32'h11);
        rd("r1_fill", M_USR, 1'b0, 4'd1, 32'h11);
        @(negedge clk);
        #2 rst = 1'b1;
        regfile_write = 1'b1; regfile_write_reg = 4'd2;
        write_mode = M_USR; regfile_write_data = 32'h22;
        read_mode = M_USR; read_0 = 4'd1; read_1 = 4'd2; read_2 = 4'd15;
        push("arst_r1", 0, 32'h0);
        push("arst_nofwd_r2", 1, 32'h0);
        push("arst_pc", 2, 32'h2008);
        drain();
        rd("arst_r3", M_USR, 1'b0, 4'd3, 32'h0);
        rd("arst_r13_svc", M_SVC, 1'b0, 4'd13, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        regfile_write_reg = 4'd5; regfile_write_data = 32'h55;
        read_0 = 4'd5; read_1 = 4'd2; read_2 = 4'd1;
        push("rel_fwd_r5", 0, 32'h55);
        push("rel_r2", 1, 32'h0);
        push("rel_r1", 2, 32'h0);
        drain();
        @(negedge clk);
        regfile_write = 1'b0;
        rd("rel_r5_stored", M_USR, 1'b0, 4'd5, 32'h55);
        rd("rel_r13_usr", M_USR, 1'b0, 4'd13, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_banked.md
# regfile_banked

Banked ARM register file; the write-side consumer of the writeback stage's `regfile_write`/`regfile_write_reg`/`regfile_write_data` outputs, and the read-side source for decode.
- Maps each architectural register number, qualified by processor mode, to a physical register.
- Commits one write per clock and serves three combinational read ports with same-cycle write forwarding.
- Holds r0–r14 only; r15 reads come from the supplied PC.

## Interface
Parameters:
- none; mode encodings and physical-index widths come from the shared package.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears every physical register to 0.
- `regfile_write`  in  1  write enable from writeback.
- `regfile_write_reg`  in  4  architectural destination register.
- `regfile_write_data`  in  32  write data.
- `write_mode`  in  5  CPSR[4:0] of the writing instruction (writeback's `outcpsr[4:0]`).
- `read_mode`  in  5  CPSR[4:0] used to bank all reads.
- `read_user`  in  1  forces user-bank mapping on all reads (LDM/STM with ^).
- `read_pc`  in  32  value returned for any read of r15 (decode supplies PC+8).
- `read_0`/`read_1`/`read_2`  in  4 each  architectural read selects.
- `rdata_0`/`rdata_1`/`rdata_2`  out  32 each  read data, combinational.

## Operation
- Modes: USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111.
  - Any other encoding maps exactly as USR.
  - SYS always maps as USR.
- Physical map:
  - r0–r7: shared by all modes.
  - r8–r12: FIQ bank in FIQ mode (see Configuration); user bank otherwise.
  - r13–r14: per-mode bank for FIQ/IRQ/SVC/ABT/UND; user bank for USR/SYS.
- Total storage: 15 user + 5 FIQ-high + 2×5 banked r13/r14 = 30 registers.
- Write: when `regfile_write`=1 and `regfile_write_reg`≠15, the physical register selected by (`regfile_write_reg`, `write_mode`) takes `regfile_write_data` at the clock edge.
  - Writes to r15 are silently dropped; branches travel on `jmp`/`jmppc`, never through this block.
- Read: `rdata_n` = `read_pc` if `read_n`=15.
  - Otherwise: the physical register selected by (`read_n`, `read_user` ? USR : `read_mode`).
- Forwarding: if a write is active this cycle and its physical index equals a read's physical index, that read returns `regfile_write_data` instead of stored data.
  - Comparison is on physical index, never architectural number: r13 written in SVC does not forward to an r13 read in USR.
- All three read ports are independent and may select the same register.

## Timing
- Write latency: 1 clock to storage; 0 cycles visible through forwarding.
- Read latency: combinational from selects, modes, `read_pc` and write inputs.
- Reset:
  - Asserting `rst` clears all 30 registers immediately, without waiting for a clock edge.
  - While `rst`=1, writes are ignored and reads of r0–r14 return 0 (forwarding suppressed).
  - Reads of r15 still return `read_pc`.
- Deassertion of `rst` mid-cycle: the first write is accepted at the next rising edge.
- Mode change between cycles needs no flush: banks are pure storage; the mapping is recomputed every cycle.

## Configuration
- `REGFILE_FIQ_BANK_EN` defined: FIQ mode banks r8–r12 in addition to r13–r14 (30 registers).
- Undefined: r8–r12 are shared by all modes, FIQ banks only r13–r14, and the 5 FIQ-high registers are not instantiated (25 registers).
  - The FIQ-high physical indices never occur.

## Structure
- Shared package:
  - mode encoding constants (`MODE_USR` … `MODE_SYS`);
  - physical-index typedef (5 bits);
  - named physical-index base constants per bank.
- Sub-module `regfile_bank_map`: combinational (architectural reg, mode) → physical index.
  - Instantiated four times: one write port, three read ports.
  - Holds the `REGFILE_FIQ_BANK_EN` conditional so storage and forwarding logic stay mode-agnostic.

## Test plan
- Reset, then read r0–r14 in every mode → all 0; `read_pc`=0x1008 with `read_0`=15 → `rdata_0`=0x1008.
- Write r13=0xAAAA0000 in SVC and r13=0x5555 in USR → SVC read gives 0xAAAA0000, USR and SYS reads give 0x5555, IRQ read gives 0.
- Write r9=0x99 in FIQ, read r9 in USR → 0 with `REGFILE_FIQ_BANK_EN`, 0x99 without; `read_user`=1 in FIQ with the macro → 0.
- Same-cycle write r3=0xDEADBEEF with `read_0`=`read_2`=3 → both return 0xDEADBEEF that cycle; r14 write in IRQ while reading r14 in USR → no forward.
- `regfile_write`=1, `regfile_write_reg`=15, data 0x1234 → no register changes; r15 read returns `read_pc`.
- Assert `rst` asynchronously between edges after filling registers → all reads of r0–r14 drop to 0 before the next edge; first write after release lands one edge later.
